// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex digit scanner feeding a nibble-to-segment decoder.
// Captured values are applied only at frame boundaries; leading zeros can be blanked.
module hex_display_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [4*DIGITS-1:0]   Data_In,
  input  logic                  Load,
  input  logic                  Blank_En,
  output logic [3:0]            Nibble,
  output logic [DIGITS-1:0]     Digit_Sel_n,
  output logic                  Blank,
  output logic                  Frame_Start,
  output logic                  Load_Ack
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]         pre_cnt;
  logic [DW-1:0]         dig_idx;
  logic [DW-1:0]         next_idx;
  logic [4*DIGITS-1:0]   shadow;
  logic [4*DIGITS-1:0]   staging;
  logic [4*DIGITS-1:0]   new_shadow;
  logic                  pending;
  logic                  tick;
  logic                  boundary;
  logic                  apply;
  logic                  zero_run;
  logic                  blank_next;
  logic [3:0]            nib_next;
  logic [DIGITS-1:0]     sel_next;

  always_comb begin
    tick     = (pre_cnt == PW'(PRESCALE - 1));
    boundary = tick && (dig_idx == DW'(DIGITS - 1));
    next_idx = (dig_idx == DW'(DIGITS - 1)) ? '0 : dig_idx + DW'(1);
    apply    = boundary && (Load || pending);

    // A load on the boundary cycle itself bypasses staging
    new_shadow = shadow;
    if (boundary && Load)
      new_shadow = Data_In;
    else if (boundary && pending)
      new_shadow = staging;

    zero_run   = 1'b1;
    blank_next = 1'b0;
    nib_next   = 4'h0;
    sel_next   = '1;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      zero_run = zero_run && (new_shadow[4*j +: 4] == 4'h0);
      if (next_idx == DW'(j)) begin
        nib_next    = new_shadow[4*j +: 4];
        sel_next[j] = 1'b0;
        blank_next  = Blank_En && (j != 0) && zero_run;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pre_cnt     <= '0;
      dig_idx     <= DW'(DIGITS - 1);
      shadow      <= '0;
      staging     <= '0;
      pending     <= 1'b0;
      Nibble      <= 4'h0;
      Digit_Sel_n <= '1;
      Blank       <= 1'b1;
      Frame_Start <= 1'b0;
      Load_Ack    <= 1'b0;
    end else begin
      Frame_Start <= 1'b0;
      Load_Ack    <= 1'b0;
      pre_cnt     <= tick ? '0 : pre_cnt + PW'(1);

      if (Load && !boundary) begin
        staging <= Data_In;
        pending <= 1'b1;
      end

      if (boundary) begin
        shadow   <= new_shadow;
        pending  <= 1'b0;
        Load_Ack <= apply;
      end

      if (tick) begin
        dig_idx     <= next_idx;
        Blank       <= blank_next;
        Nibble      <= blank_next ? 4'h0 : nib_next;
        Digit_Sel_n <= blank_next ? '1 : sel_next;
        Frame_Start <= (next_idx == '0);
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: a frame-level reference model predicts
// every cycle's outputs; a monitor process pops and compares after each rising edge.
module tb_hex_display_scanner;

  localparam int D = 4;
  localparam int P = 4;

  logic        Clk;
  logic        Reset;
  logic [15:0] Data_In;
  logic        Load;
  logic        Blank_En;
  logic [3:0]  Nibble;
  logic [3:0]  Digit_Sel_n;
  logic        Blank;
  logic        Frame_Start;
  logic        Load_Ack;

  hex_display_scanner #(.DIGITS(D), .PRESCALE(P)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Data_In     (Data_In),
    .Load        (Load),
    .Blank_En    (Blank_En),
    .Nibble      (Nibble),
    .Digit_Sel_n (Digit_Sel_n),
    .Blank       (Blank),
    .Frame_Start (Frame_Start),
    .Load_Ack    (Load_Ack)
  );

  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] sel;
    logic       blank;
    logic       fs;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // reference model state: edges since reset release, displayed and staged values
  int          e;
  logic [15:0] disp;
  logic [15:0] staged;
  bit          has_staged;
  exp_t        cur;
  logic        ben_r;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic bit next_is_boundary();
    int n;
    n = e + 1;
    return (n % P == 0) && ((n / P - 1) % D == 0);
  endfunction

  task automatic model(input logic rst, input logic ld, input logic [15:0] din, input logic ben);
    bit tick, bnd;
    int k;
    if (!rst) begin
      e = 0; disp = '0; staged = '0; has_staged = 0;
      cur = '{nib: 4'h0, sel: 4'hF, blank: 1'b1, fs: 1'b0, ack: 1'b0};
    end else begin
      e++;
      tick = (e % P == 0);
      k    = tick ? (e / P - 1) % D : 0;
      bnd  = tick && (k == 0);
      cur.fs  = 1'b0;
      cur.ack = 1'b0;
      if (bnd) begin
        if (ld) begin disp = din; cur.ack = 1'b1; end
        else if (has_staged) begin disp = staged; cur.ack = 1'b1; end
        has_staged = 0;
      end else if (ld) begin
        staged = din; has_staged = 1;
      end
      if (tick) begin
        cur.blank = ben && (k != 0) && ((disp >> (4 * k)) == 16'h0);
        cur.nib   = cur.blank ? 4'h0 : 4'(disp >> (4 * k));
        cur.sel   = cur.blank ? 4'hF : ~(4'b0001 << k);
        cur.fs    = (k == 0);
      end
    end
    exp_q.push_back(cur);
  endtask

  task automatic step(input logic rst, input logic ld, input logic [15:0] din);
    Reset = rst; Load = ld; Data_In = din; Blank_En = ben_r;
    model(rst, ld, din, ben_r);
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, $urandom());
  endtask

  task automatic load_mid(input logic [15:0] v);
    for (int i = 0; i < 4 && next_is_boundary(); i++) idle(1);
    step(1'b1, 1'b1, v);
  endtask

  // idle until the most recent edge was a frame boundary
  task automatic align_frame();
    for (int i = 0; i < 2 * P * D && (e % (P * D)) != P; i++) idle(1);
  endtask

  initial begin : monitor
    exp_t ex, act;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        ex  = exp_q.pop_front();
        act = '{nib: Nibble, sel: Digit_Sel_n, blank: Blank, fs: Frame_Start, ack: Load_Ack};
        tests++;
        if (act !== ex) begin
          fails++;
          $display("FAIL cycle_outputs t=%0t actual nib=%h sel=%b blank=%b fs=%b ack=%b required nib=%h sel=%b blank=%b fs=%b ack=%b",
                   $time, act.nib, act.sel, act.blank, act.fs, act.ack,
                   ex.nib, ex.sel, ex.blank, ex.fs, ex.ack);
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    logic [15:0] v;
    ben_r = 1'b0;
    e = 0; disp = '0; staged = '0; has_staged = 0; cur = '0;

    // reset held three cycles, then free-run into the first frame
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'hFFFF);
    idle(10);

    load_mid(16'h1A2F);
    idle(40);

    ben_r = 1'b1;
    load_mid(16'h0030);
    idle(36);
    load_mid(16'h0000);
    idle(36);

    ben_r = 1'b0;
    align_frame();
    step(1'b1, 1'b1, 16'h1111);
    idle(1);
    step(1'b1, 1'b1, 16'h2222);
    idle(40);

    load_mid(16'h1234);
    for (int i = 0; i < 2 * P * D && !next_is_boundary(); i++) idle(1);
    step(1'b1, 1'b1, 16'hBEEF);
    idle(36);

    align_frame();
    step(1'b1, 1'b1, 16'h5555);
    idle(2);
    step(1'b0, 1'b0, 16'h0);
    idle(40);

    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r == 50) ben_r = 1'($urandom_range(0, 1));
      if (r < 2) begin
        step(1'b0, 1'b0, 16'h0);
      end else if (r < 14) begin
        v = 16'($urandom());
        if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(0, 3));
        step(1'b1, 1'b1, v);
      end else begin
        idle(1);
      end
    end
    idle(2);

    @(posedge Clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain actual %0d left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
